// File: rtl/shift_arbiter_64.sv
// Two-requester round-robin front end for one shared 64-bit logarithmic left shifter.
// Optional saturating per-requester grant counters are enabled with `define SHIFT_STATS_EN.
module shift_arbiter_64 #(
  parameter logic        RR_INIT = 1'b0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic        req0_w,
  input  logic [63:0] req0_data,
  input  logic [5:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic        req1_w,
  input  logic [63:0] req1_data,
  input  logic [5:0]  req1_shamt,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_id
`ifdef SHIFT_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("shift_arbiter_64: CNT_W must be at least 1");
  end

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  // Six fixed-distance stages (1,2,4,8,16,32), each enabled by one amount bit.
  function automatic logic [63:0] sll64(input logic [63:0] x, input logic [5:0] amt);
    logic [63:0] s;
    s = x;
    for (int i = 0; i < 6; i++) begin
      if (amt[i]) s = s << (1 << i);
    end
    return s;
  endfunction

  logic        rr_ptr;
  logic        can_accept;
  logic        grant_any;
  logic        grant_id;

  logic [1:0]  sel_op;
  logic        sel_w;
  logic [63:0] sel_data;
  logic [5:0]  sel_shamt;

  logic        is_right;
  logic        is_arith;
  logic        sign;
  logic        invert;
  logic [5:0]  amt;
  logic [63:0] x;
  logic [63:0] core_in;
  logic [63:0] core_out;
  logic [63:0] shifted;
  logic [63:0] shift_res;

  // Readies are combinational from the valids and res_ready; reset masks them.
  always_comb begin
    can_accept = !res_valid || res_ready;
    grant_id   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    grant_any  = !rst && can_accept && (req0_valid || req1_valid);
    req0_ready = grant_any && !grant_id;
    req1_ready = grant_any && grant_id;
  end

  always_comb begin
    sel_op    = grant_id ? req1_op    : req0_op;
    sel_w     = grant_id ? req1_w     : req0_w;
    sel_data  = grant_id ? req1_data  : req0_data;
    sel_shamt = grant_id ? req1_shamt : req0_shamt;

    // Reserved op 2'b10 has op[0]=0 and so falls through as SLL.
    is_right = sel_op[0];
    is_arith = (sel_op == 2'b11);
    amt      = sel_w ? {1'b0, sel_shamt[4:0]} : sel_shamt;
    sign     = sel_w ? sel_data[31] : sel_data[63];

    if (!sel_w)        x = sel_data;
    else if (is_arith) x = {{32{sel_data[31]}}, sel_data[31:0]};
    else               x = {32'b0, sel_data[31:0]};

    // A negative SRA is ~srl(~x): same as ORing in a fill mask of amt ones,
    // but keeps the datapath to a single shifter instance.
    invert   = is_arith && sign;
    core_in  = invert ? ~x : x;
    core_out = is_right ? rev64(sll64(rev64(core_in), amt)) : sll64(core_in, amt);
    shifted  = invert ? ~core_out : core_out;

    shift_res = sel_w ? {{32{shifted[31]}}, shifted[31:0]} : shifted;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; res_data is reset too because its reset value is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      rr_ptr    <= RR_INIT;
    end else if (grant_any) begin
      res_valid <= 1'b1;
      res_data  <= shift_res;
      res_id    <= grant_id;
      rr_ptr    <= ~grant_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef SHIFT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter_64.sv
// Directed bench for shift_arbiter_64: reset, opcode decode, round robin,
// back-pressure and mid-stream reset, with hand-computed expected values.
module tb_shift_arbiter_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_w;
  logic [1:0]  req0_op;
  logic [63:0] req0_data;
  logic [5:0]  req0_shamt;
  logic        req1_valid, req1_ready, req1_w;
  logic [1:0]  req1_op;
  logic [63:0] req1_data;
  logic [5:0]  req1_shamt;
  logic        res_valid, res_ready, res_id;
  logic [63:0] res_data;
`ifdef SHIFT_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_arbiter_64 #(.RR_INIT(1'b0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_w(req0_w), .req0_data(req0_data), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_w(req1_w), .req1_data(req1_data), .req1_shamt(req1_shamt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
`ifdef SHIFT_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  task automatic drive_req(input logic id, input logic v, input logic [1:0] op,
                           input logic w, input logic [63:0] d, input logic [5:0] s);
    if (!id) begin
      req0_valid = v; req0_op = op; req0_w = w; req0_data = d; req0_shamt = s;
    end else begin
      req1_valid = v; req1_op = op; req1_w = w; req1_data = d; req1_shamt = s;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    res_ready = 1'b0;
    drive_req(1'b0, 1'b1, 2'b00, 1'b0, 64'h1, 6'd0);
    drive_req(1'b1, 1'b1, 2'b00, 1'b0, 64'h2, 6'd0);
    @(posedge clk); #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", req1_ready); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_data !== 64'h0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id: got %b expected 0", res_id); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_readies: got %b%b expected 00", req0_ready, req1_ready);
    end
`ifdef SHIFT_STATS_EN
    checks++; if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1);
    end
`endif
    drive_req(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 6'd0);
    drive_req(1'b1, 1'b0, 2'b00, 1'b0, 64'h0, 6'd0);
    rst = 1'b0;
  endtask

  // One lone request through the shifter, consumer always ready.
  task automatic run_op(input string name, input logic id, input logic [1:0] op,
                        input logic w, input logic [63:0] d, input logic [5:0] s,
                        input logic [63:0] exp);
    logic rdy;
    res_ready = 1'b1;
    drive_req(id, 1'b1, op, w, d, s);
    #1;
    rdy = id ? req1_ready : req0_ready;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", name, rdy); end
    @(posedge clk); #1;
    drive_req(id, 1'b0, 2'b00, 1'b0, 64'h0, 6'd0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, res_valid); end
    checks++; if (res_data !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", name, res_data, exp); end
    checks++; if (res_id !== id) begin errors++; $display("FAIL %s_id: got %b expected %b", name, res_id, id); end
  endtask

  task automatic test_single_ops();
    run_op("sll63",     1'b0, 2'b00, 1'b0, 64'h0000000000000001, 6'd63, 64'h8000000000000000);
    run_op("sra4",      1'b1, 2'b11, 1'b0, 64'h8000000000000000, 6'd4,  64'hF800000000000000);
    run_op("sraw36",    1'b1, 2'b11, 1'b1, 64'h0000000080000000, 6'd36, 64'hFFFFFFFFF8000000);
    run_op("srlw31",    1'b0, 2'b01, 1'b1, 64'hFFFFFFFF80000000, 6'd31, 64'h0000000000000001);
    run_op("srl63",     1'b0, 2'b01, 1'b0, 64'h8000000000000000, 6'd63, 64'h0000000000000001);
    run_op("rsvd_sll",  1'b1, 2'b10, 1'b0, 64'h0000000000000003, 6'd1,  64'h0000000000000006);
    run_op("sllw31",    1'b0, 2'b00, 1'b1, 64'h0000000000000001, 6'd31, 64'hFFFFFFFF80000000);
    run_op("sra0",      1'b1, 2'b11, 1'b0, 64'h8000000000000001, 6'd0,  64'h8000000000000001);
    run_op("sllw0",     1'b0, 2'b00, 1'b1, 64'h1234567887654321, 6'd0,  64'hFFFFFFFF87654321);
    run_op("sllw33",    1'b1, 2'b00, 1'b1, 64'h0000000000000001, 6'd33, 64'h0000000000000002);
    run_op("sra_pos",   1'b0, 2'b11, 1'b0, 64'h4000000000000000, 6'd2,  64'h1000000000000000);
    run_op("sraw_pos",  1'b1, 2'b11, 1'b1, 64'hFFFFFFFF40000000, 6'd1,  64'h0000000020000000);
  endtask

  task automatic test_drain();
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", res_valid); end
  endtask

  task automatic test_round_robin();
    logic exp;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    drive_req(1'b0, 1'b1, 2'b00, 1'b0, 64'h11, 6'd0);
    drive_req(1'b1, 1'b1, 2'b00, 1'b0, 64'h22, 6'd4);
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1);
      #1;
      checks++; if (req0_ready !== !exp || req1_ready !== exp) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b%b expected %b%b", i, req0_ready, req1_ready, !exp, exp);
      end
      @(posedge clk); #1;
      checks++; if (res_id !== exp) begin errors++; $display("FAIL rr_id[%0d]: got %b expected %b", i, res_id, exp); end
      checks++; if (res_data !== (exp ? 64'h220 : 64'h11)) begin
        errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, res_data, exp ? 64'h220 : 64'h11);
      end
    end
`ifdef SHIFT_STATS_EN
    checks++; if (grant_cnt0 !== 32'd2 || grant_cnt1 !== 32'd2) begin
      errors++; $display("FAIL rr_counters: got %0d/%0d expected 2/2", grant_cnt0, grant_cnt1);
    end
`endif
  endtask

  // Entered with both requesters valid and requester 1 granted last.
  task automatic test_backpressure();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b%b expected 00", i, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== 64'h220) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%b d=%h expected v=1 id=1 d=220", i, res_valid, res_id, res_data);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++; if (res_id !== 1'b0 || res_data !== 64'h11) begin
      errors++; $display("FAIL bp_release_res: got id=%b d=%h expected id=0 d=11", res_id, res_data);
    end
    @(posedge clk); #1;
    checks++; if (res_id !== 1'b1 || res_data !== 64'h220) begin
      errors++; $display("FAIL bp_next_res: got id=%b d=%h expected id=1 d=220", res_id, res_data);
    end
  endtask

  // Entered streaming; one more grant to requester 0 leaves rr_ptr at 1 before reset.
  task automatic test_reset_midstream();
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_id !== 1'b0) begin
      errors++; $display("FAIL mid_pre: got v=%b id=%b expected v=1 id=0", res_valid, res_id);
    end
    rst = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || res_data !== 64'h0 || res_id !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out: got v=%b d=%h id=%b expected v=0 d=0 id=0", res_valid, res_data, res_id);
    end
`ifdef SHIFT_STATS_EN
    checks++; if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin
      errors++; $display("FAIL mid_rst_counters: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1);
    end
`endif
    rst = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rr_init: got %b%b expected 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 64'h11) begin
      errors++; $display("FAIL mid_first: got v=%b id=%b d=%h expected v=1 id=0 d=11", res_valid, res_id, res_data);
    end
    drive_req(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 6'd0);
    drive_req(1'b1, 1'b0, 2'b00, 1'b0, 64'h0, 6'd0);
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_drain();
    test_round_robin();
    test_backpressure();
    test_reset_midstream();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
